// File: rtl/key_event_pkg.sv
// key_event_pkg: keyboard action codes, HID keycode constants and the shared keycode decoder
package key_event_pkg;
  typedef enum logic [2:0] {
    ACT_NONE, ACT_PREV, ACT_NEXT, ACT_UP, ACT_DOWN, ACT_LEFT, ACT_RIGHT, ACT_FIRE
  } action_t;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  localparam logic [7:0] KC_Q = 8'h14;
  localparam logic [7:0] KC_E = 8'h08;
  localparam logic [7:0] KC_W = 8'h1A;
  localparam logic [7:0] KC_S = 8'h16;
  localparam logic [7:0] KC_A = 8'h04;
  localparam logic [7:0] KC_D = 8'h07;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  function automatic action_t keycode_to_action(input logic [7:0] kc);
    return kc == KC_Q ? ACT_PREV :
           kc == KC_E ? ACT_NEXT :
           kc == KC_W ? ACT_UP :
           kc == KC_S ? ACT_DOWN :
           kc == KC_A ? ACT_LEFT :
           kc == KC_D ? ACT_RIGHT :
           kc == KC_SPACE ? ACT_FIRE : ACT_NONE;
  endfunction
endpackage

// File: rtl/key_repeat_timer.sv
// key_repeat_timer: tick counter that pulses expire on the tick where limit ticks have elapsed
module key_repeat_timer #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         expire
);
  logic [W-1:0] cnt;
  assign expire = tick && cnt == limit - 1'b1;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (tick) cnt <= expire ? '0 : cnt + 1'b1;
endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder: registered HID keycode to one-cycle action events with per-frame auto-repeat
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE = 6,
  parameter bit FIRE_REPEAT = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [7:0] keycode,
  output logic       action_valid,
  output logic [2:0] action_code,
  output logic       action_repeat,
  output logic       key_held
);
  localparam int MAXL = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = $clog2(MAXL) + 1;
  logic [7:0] keycodeQ;
  state_t state, nextState;
  action_t act, curAct, nextCur;
  logic validQ, emit, emitRep, fresh, timerClear, timerTick, expire;
  logic [CW-1:0] limit;
  assign act = keycode_to_action(keycodeQ);
  assign fresh = state == IDLE || act != curAct;
  assign timerClear = !enable || (frame_tick && (act == ACT_NONE || fresh));
  // a held non-repeating FIRE never advances the timer, so it parks in DELAY
  assign timerTick = frame_tick && (FIRE_REPEAT || curAct != ACT_FIRE);
  assign limit = state == DELAY ? CW'(REPEAT_DELAY) : CW'(REPEAT_RATE);
  key_repeat_timer #(.W(CW)) timer (
    .Clk(Clk),
    .Reset(Reset),
    .clear(timerClear),
    .tick(timerTick),
    .limit(limit),
    .expire(expire)
  );
  always_comb begin
    nextState = state;
    nextCur = curAct;
    emit = 1'b0;
    emitRep = 1'b0;
    if (!enable) nextState = IDLE;
    else if (frame_tick) begin
      if (act == ACT_NONE) nextState = IDLE;
      else if (fresh) begin
        emit = 1'b1;
        nextCur = act;
        nextState = DELAY;
      end else if (expire) begin
        emit = 1'b1;
        emitRep = 1'b1;
        nextState = REPEAT;
      end
    end
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      keycodeQ <= '0;
      state <= IDLE;
      curAct <= ACT_NONE;
      validQ <= 1'b0;
      action_code <= '0;
      action_repeat <= 1'b0;
    end else begin
      keycodeQ <= keycode;
      state <= nextState;
      curAct <= nextCur;
      validQ <= emit;
      if (emit) begin
        action_code <= act;
        action_repeat <= emitRep;
      end
    end
  // disabling suppresses a pending pulse in the same cycle
  assign action_valid = validQ && enable;
  assign key_held = state != IDLE;
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: three parameterisations checked every cycle against a frame-count model
module tb_key_event_decoder;
  logic Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0, enable = 1'b1;
  logic [7:0] keycode = 8'h14;
  logic av[3], ar[3], kh[3];
  logic [2:0] ac[3];
  int checks = 0, errors = 0, tickCount = 0;
  int evCnt[3] = '{0, 0, 0};
  string evA = "";
  logic [7:0] mKq[3] = '{8'h00, 8'h00, 8'h00};
  int mCur[3] = '{0, 0, 0}, mN[3] = '{0, 0, 0}, eC[3] = '{0, 0, 0};
  bit mHeld[3], eV[3], eR[3];

  always #5 Clk = ~Clk;

  key_event_decoder #(.REPEAT_DELAY(3), .REPEAT_RATE(2), .FIRE_REPEAT(1'b0)) dutA (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable), .keycode(keycode),
    .action_valid(av[0]), .action_code(ac[0]), .action_repeat(ar[0]), .key_held(kh[0]));
  key_event_decoder #(.REPEAT_DELAY(3), .REPEAT_RATE(2), .FIRE_REPEAT(1'b1)) dutB (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable), .keycode(keycode),
    .action_valid(av[1]), .action_code(ac[1]), .action_repeat(ar[1]), .key_held(kh[1]));
  key_event_decoder #(.REPEAT_DELAY(1), .REPEAT_RATE(1), .FIRE_REPEAT(1'b1)) dutC (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable), .keycode(keycode),
    .action_valid(av[2]), .action_code(ac[2]), .action_repeat(ar[2]), .key_held(kh[2]));

  function automatic int rdOf(int i); return i == 2 ? 1 : 3; endfunction
  function automatic int rrOf(int i); return i == 2 ? 1 : 2; endfunction
  function automatic int mapKey(logic [7:0] k);
    case (k)
      8'h14: return 1;
      8'h08: return 2;
      8'h1A: return 3;
      8'h16: return 4;
      8'h04: return 5;
      8'h07: return 6;
      8'h2C: return 7;
      default: return 0;
    endcase
  endfunction

  // model: count ticks since the press; repeat at REPEAT_DELAY, then every REPEAT_RATE
  always @(posedge Clk) begin : model
    int a;
    for (int i = 0; i < 3; i++) begin
      if (Reset) begin
        mKq[i] = 8'h00; mHeld[i] = 0; eV[i] = 0; eC[i] = 0; eR[i] = 0;
      end else begin
        a = mapKey(mKq[i]);
        eV[i] = 0;
        if (!enable) mHeld[i] = 0;
        else if (frame_tick) begin
          if (a == 0) mHeld[i] = 0;
          else if (!mHeld[i] || a != mCur[i]) begin
            mHeld[i] = 1; mCur[i] = a; mN[i] = 0; eV[i] = 1; eC[i] = a; eR[i] = 0;
          end else begin
            mN[i]++;
            if ((i != 0 || mCur[i] != 7) &&
                (mN[i] == rdOf(i) || (mN[i] > rdOf(i) && (mN[i] - rdOf(i)) % rrOf(i) == 0))) begin
              eV[i] = 1; eR[i] = 1;
            end
          end
        end
        mKq[i] = keycode;
      end
    end
  end

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic strChk(string nm, string got, string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, got, exp);
    end
  endtask

  always @(negedge Clk) begin : compare
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid%0d", i), {7'd0, av[i]}, {7'd0, eV[i]});
      chk($sformatf("code%0d", i), {5'd0, ac[i]}, 8'(eC[i]));
      chk($sformatf("repeat%0d", i), {7'd0, ar[i]}, {7'd0, eR[i]});
      chk($sformatf("held%0d", i), {7'd0, kh[i]}, {7'd0, mHeld[i]});
      if (av[i] === 1'b1) evCnt[i]++;
    end
    if (av[0] === 1'b1) evA = {evA, $sformatf("%0d%s ", tickCount - 1, ar[0] ? "r" : "p")};
  end

  task automatic step(int n);
    repeat (n) begin
      @(negedge Clk);
      #2;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    tickCount++;
    step(1);
    frame_tick = 1'b0;
    step(3);
  endtask

  task automatic key(logic [7:0] k);
    keycode = k;
    step(1);
  endtask

  task automatic startTest();
    key(8'h00);
    tick();
    step(1);
    evA = "";
    evCnt = '{0, 0, 0};
    tickCount = 0;
  endtask

  initial begin
    step(1);
    tick();
    tick();
    chk("t1_resetNoEvents", 8'(evCnt[0] + evCnt[1] + evCnt[2]), 8'd0);
    chk("t1_resetValid", {7'd0, av[0]}, 8'd0);
    Reset = 1'b0;
    step(2);
    tickCount = 0;
    evA = "";
    tick();
    strChk("t1_pressAfterReset", evA, "0p ");
    chk("t1_code", {5'd0, ac[0]}, 8'd1);

    startTest();
    key(8'h08);
    repeat (10) tick();
    strChk("t2_repeatTicks", evA, "0p 3r 5r 7r 9r ");
    chk("t2_code", {5'd0, ac[0]}, 8'd2);

    startTest();
    key(8'h1A);
    repeat (2) tick();
    key(8'h16);
    repeat (4) tick();
    strChk("t3_switch", evA, "0p 2p 5r ");
    chk("t3_code", {5'd0, ac[0]}, 8'd4);

    startTest();
    key(8'h2C);
    repeat (50) tick();
    chk("t4_fireNoRepeat", 8'(evCnt[0]), 8'd1);
    chk("t4_fireRepeat", 8'(evCnt[1]), 8'd25);
    chk("t4_fireEveryTick", 8'(evCnt[2]), 8'd50);
    chk("t4_code", {5'd0, ac[0]}, 8'd7);

    startTest();
    key(8'h29);
    repeat (10) tick();
    key(8'h00);
    repeat (10) tick();
    keycode = 8'h04;
    step(1);
    keycode = 8'h00;
    step(2);
    tick();
    chk("t5_noEvents", 8'(evCnt[0] + evCnt[1] + evCnt[2]), 8'd0);
    chk("t5_notHeld", {7'd0, kh[0]}, 8'd0);

    startTest();
    key(8'h07);
    repeat (4) tick();
    enable = 1'b0;
    step(1);
    repeat (3) tick();
    chk("t6_heldWhileDisabled", {7'd0, kh[0]}, 8'd0);
    enable = 1'b1;
    step(1);
    tick();
    strChk("t6_reenable", evA, "0p 3r 7p ");
    chk("t6_code", {5'd0, ac[0]}, 8'd6);

    startTest();
    key(8'h14);
    repeat (2) tick();
    Reset = 1'b1;
    step(1);
    chk("t7_resetCode", {5'd0, ac[0]}, 8'd0);
    chk("t7_resetHeld", {7'd0, kh[0]}, 8'd0);
    Reset = 1'b0;
    step(1);
    tick();
    strChk("t7_pressAfterReset", evA, "0p 2p ");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
